matvec_mac_ctrl: RTL and testbench
==================================

Name: matvec_mac_ctrl

Overview:
- Sequencing controller for the saturating multiply-accumulate datapath and its two operand memories (matrix and vector).
- Accepts a stream of matrix words, then vector words, into the memories.
- Then runs M rows of N-term dot products through the datapath, driving `clear_acc`/`en_acc` and the memory read addresses.
- Presents one result per row over a valid/ready handshake.

Parameters:
- M, 3, number of matrix rows (= number of outputs per job); M >= 1
- N, 3, number of matrix columns (= vector length = terms per dot product); N >= 1
- AM, $clog2(M*N) (minimum 1), matrix memory address width
- AV, $clog2(N) (minimum 1), vector memory address width

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- input_valid  input  1  upstream word valid (data bus routed directly to both memories)
- input_ready  output  1  controller accepts an input word this cycle
- wr_en_m  output  1  matrix memory write enable
- wr_en_v  output  1  vector memory write enable
- addr_m  output  AM  matrix memory address (write and read)
- addr_v  output  AV  vector memory address (write and read)
- clear_acc  output  1  datapath accumulator clear
- en_acc  output  1  datapath accumulate/output-register enable
- output_valid  output  1  datapath output_data holds a finished row result
- output_ready  input  1  downstream accepts the result

Behaviour:
- Reset (asynchronous, active-high): state=LOAD_M, all counters 0, and all outputs 0 except `input_ready`=1 in LOAD_M.
  - Reset mid-load or mid-compute aborts the job.
  - Memory contents are not cleared.
- Memories: synchronous read, 1-cycle latency. Address presented in cycle k gives m_out/v_out in cycle k+1.
- Datapath contract: `output_data` registers the pre-add accumulator on each `en_acc` edge. One extra (flush) `en_acc` cycle is therefore required after N terms.
- States: LOAD_M, LOAD_V, CLEAR, ACC, FLUSH, OUT.
- LOAD_M:
  - `input_ready`=1.
  - `wr_en_m` = `input_valid` (combinational); `addr_m` = load count.
  - Each accepted word increments the count.
  - After the word at M*N-1 is accepted: count=0, go to LOAD_V.
- LOAD_V: same as LOAD_M, using `wr_en_v`/`addr_v` and N words. After the last word go to CLEAR with row=0.
- CLEAR (1 cycle):
  - `clear_acc`=1, `input_ready`=0.
  - `addr_m` = row*N, `addr_v` = 0; col=0.
  - Go to ACC.
- ACC (N cycles):
  - `en_acc`=1.
  - `addr_m` = row*N + col + 1 and `addr_v` = col + 1 while col+1 < N; otherwise hold the last address (don't-care).
  - col increments each cycle. When col=N-1, go to FLUSH.
- FLUSH (1 cycle): `en_acc`=1; go to OUT. The corrupted accumulator value is discarded by the next CLEAR.
- OUT:
  - `output_valid`=1, `en_acc`=0, `clear_acc`=0. Hold until `output_ready`.
  - On `output_valid` & `output_ready`: if row < M-1, row++ and go to CLEAR; else go to LOAD_M (job done).
- Latency: from the last vector word accepted to the first `output_valid` is N+2 cycles. Each subsequent row takes N+2 cycles after the previous handshake.
- `output_ready` asserted while not in OUT has no effect. `input_valid` while `input_ready`=0 is ignored (no write).
- `clear_acc` and `en_acc` are never both 1.
- Edge case N=1: ACC lasts 1 cycle.
- Edge case M=1: OUT returns directly to load.
- All outputs except the load-phase write enables are registered-state decodes; no combinational path from `output_ready` to any output.

Optional Feature:
- Macro MATRIX_REUSE_EN.
- Defined: a 1-bit flag `m_loaded` is set after the first complete matrix load and cleared only by reset. End of job (and entry after reset once the flag is set) goes to LOAD_V instead of LOAD_M, so later jobs stream only N vector words against the stored matrix.
- Undefined: every job loads M*N matrix words then N vector words.

Test Plan (M=3, N=3 unless stated):
- Reset then 12 words with `input_valid` held high:
  - Expect `wr_en_m` on addresses 0..8, then `wr_en_v` on 0..2.
  - Expect `clear_acc` 1 cycle after the 12th word, `en_acc` for 4 cycles, then `output_valid`.
  - Matrix rows {1,2,3},{4,5,6},{7,8,9} with v={1,1,1} give outputs 6, 15, 24.
- Saturation path: all matrix words 2047 and v={2047,2047,2047} (WIDTH=12). Expect 3 outputs of 2047, with `output_valid` asserting N+2=5 cycles after each handshake.
- Backpressure: hold `output_ready`=0 for 10 cycles on row 1. `output_valid` stays 1, `en_acc`/`clear_acc` stay 0, and no address change; row 2 starts the cycle after `ready`.
- Bubbled input: `input_valid` toggling 1,0,1,0 gives exactly 12 writes, with addresses incrementing only on accepted words.
- Reset asserted during ACC of row 2: all outputs go to 0 immediately, state returns to LOAD_M, and a full 12-word reload computes correct results.
- MATRIX_REUSE_EN: after job 1, send only 3 vector words {2,0,1}. Expect no `wr_en_m` and outputs 5, 14, 23.

Source files
------------

// File: rtl/matvec_mac_ctrl.sv
// Sequencing controller for a matrix-vector multiply-accumulate datapath: loads operand memories, runs M dot products, hands out results.
// Optional MATRIX_REUSE_EN: once a matrix is loaded, later jobs stream only the vector.
module matvec_mac_ctrl #(
    parameter int M  = 3,
    parameter int N  = 3,
    parameter int AM = (M * N > 1) ? $clog2(M * N) : 1,
    parameter int AV = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          input_valid,
    output logic          input_ready,
    output logic          wr_en_m,
    output logic          wr_en_v,
    output logic [AM-1:0] addr_m,
    output logic [AV-1:0] addr_v,
    output logic          clear_acc,
    output logic          en_acc,
    output logic          output_valid,
    input  logic          output_ready
);

    localparam int RW = (M > 1) ? $clog2(M) : 1;
    localparam logic [AM-1:0] LastM   = AM'(M * N - 1);
    localparam logic [AV-1:0] LastV   = AV'(N - 1);
    localparam logic [AV-1:0] LastCol = AV'(N - 1);
    localparam logic [RW-1:0] LastRow = RW'(M - 1);

    typedef enum logic [2:0] {LOAD_M, LOAD_V, CLEAR, ACC, FLUSH, OUT} state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [AV-1:0] col_q, col_d;
    logic [AM-1:0] base_q, base_d;
    logic [AM-1:0] addr_m_q, addr_m_d;
    logic [AV-1:0] addr_v_q, addr_v_d;
    logic          ready_q, ready_d;
    logic          clear_q, clear_d;
    logic          en_q, en_d;
    logic          valid_q, valid_d;
`ifdef MATRIX_REUSE_EN
    logic          m_loaded_q, m_loaded_d;
`endif

    // The load counters double as the memory write addresses; base_q tracks row*N without a multiplier.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        base_d   = base_q;
        addr_m_d = addr_m_q;
        addr_v_d = addr_v_q;
`ifdef MATRIX_REUSE_EN
        m_loaded_d = m_loaded_q;
`endif
        case (state_q)
            LOAD_M: begin
                if (input_valid) begin
                    if (addr_m_q == LastM) begin
                        addr_m_d = '0;
                        state_d  = LOAD_V;
`ifdef MATRIX_REUSE_EN
                        m_loaded_d = 1'b1;
`endif
                    end else begin
                        addr_m_d = addr_m_q + AM'(1);
                    end
                end
            end
            LOAD_V: begin
                if (input_valid) begin
                    if (addr_v_q == LastV) begin
                        addr_v_d = '0;
                        addr_m_d = '0;
                        base_d   = '0;
                        row_d    = '0;
                        col_d    = '0;
                        state_d  = CLEAR;
                    end else begin
                        addr_v_d = addr_v_q + AV'(1);
                    end
                end
            end
            CLEAR: begin
                state_d = ACC;
                col_d   = '0;
                if (N > 1) begin
                    addr_m_d = base_q + AM'(1);
                    addr_v_d = AV'(1);
                end
            end
            ACC: begin
                if (col_q == LastCol) begin
                    state_d = FLUSH;
                end else begin
                    col_d = col_q + AV'(1);
                    // Prefetch one term ahead to cover the memory read latency.
                    if (int'(col_q) + 2 < N) begin
                        addr_m_d = base_q + AM'(col_q) + AM'(2);
                        addr_v_d = col_q + AV'(2);
                    end
                end
            end
            FLUSH: begin
                state_d = OUT;
            end
            OUT: begin
                if (output_ready) begin
                    addr_v_d = '0;
                    if (row_q == LastRow) begin
                        addr_m_d = '0;
`ifdef MATRIX_REUSE_EN
                        state_d = m_loaded_q ? LOAD_V : LOAD_M;
`else
                        state_d = LOAD_M;
`endif
                    end else begin
                        row_d    = row_q + RW'(1);
                        base_d   = base_q + AM'(N);
                        addr_m_d = base_q + AM'(N);
                        state_d  = CLEAR;
                    end
                end
            end
            default: state_d = LOAD_M;
        endcase

        ready_d = (state_d == LOAD_M) || (state_d == LOAD_V);
        clear_d = (state_d == CLEAR);
        en_d    = (state_d == ACC) || (state_d == FLUSH);
        valid_d = (state_d == OUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= LOAD_M;
            row_q    <= '0;
            col_q    <= '0;
            base_q   <= '0;
            addr_m_q <= '0;
            addr_v_q <= '0;
            ready_q  <= 1'b1;
            clear_q  <= 1'b0;
            en_q     <= 1'b0;
            valid_q  <= 1'b0;
`ifdef MATRIX_REUSE_EN
            m_loaded_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            base_q   <= base_d;
            addr_m_q <= addr_m_d;
            addr_v_q <= addr_v_d;
            ready_q  <= ready_d;
            clear_q  <= clear_d;
            en_q     <= en_d;
            valid_q  <= valid_d;
`ifdef MATRIX_REUSE_EN
            m_loaded_q <= m_loaded_d;
`endif
        end
    end

    assign input_ready  = ready_q;
    assign wr_en_m      = input_valid && (state_q == LOAD_M);
    assign wr_en_v      = input_valid && (state_q == LOAD_V);
    assign addr_m       = addr_m_q;
    assign addr_v       = addr_v_q;
    assign clear_acc    = clear_q;
    assign en_acc       = en_q;
    assign output_valid = valid_q;

endmodule

// File: tb/tb_matvec_mac_ctrl.sv
// Testbench for matvec_mac_ctrl: behavioural memories and saturating datapath around the controller, scoreboarded results.
// Define MATRIX_REUSE_EN to also exercise the matrix-reuse job.
module tb_matvec_mac_ctrl;

    localparam int M  = 3;
    localparam int N  = 3;
    localparam int AM = 4;
    localparam int AV = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          input_valid;
    logic          input_ready;
    logic          wr_en_m;
    logic          wr_en_v;
    logic [AM-1:0] addr_m;
    logic [AV-1:0] addr_v;
    logic          clear_acc;
    logic          en_acc;
    logic          output_valid;
    logic          output_ready;

    logic signed [11:0] in_data;
    logic signed [11:0] memM [16];
    logic signed [11:0] memV [4];
    logic signed [11:0] mOut;
    logic signed [11:0] vOut;
    int acc;
    int outData;

    int nChecks = 0;
    int nFails  = 0;
    int expQ[$];
    int mWrites = 0;
    int vWrites = 0;

    always #5 clk = ~clk;

    matvec_mac_ctrl #(.M(M), .N(N), .AM(AM), .AV(AV)) dut (
        .clk(clk),
        .reset(reset),
        .input_valid(input_valid),
        .input_ready(input_ready),
        .wr_en_m(wr_en_m),
        .wr_en_v(wr_en_v),
        .addr_m(addr_m),
        .addr_v(addr_v),
        .clear_acc(clear_acc),
        .en_acc(en_acc),
        .output_valid(output_valid),
        .output_ready(output_ready)
    );

    function automatic int sat12(int x);
        if (x > 2047) return 2047;
        if (x < -2048) return -2048;
        return x;
    endfunction

    // Output register captures the accumulator before the add, hence the flush cycle.
    always @(posedge clk) begin
        if (wr_en_m) memM[addr_m] <= in_data;
        if (wr_en_v) memV[addr_v] <= in_data;
        mOut <= memM[addr_m];
        vOut <= memV[addr_v];
        if (clear_acc) begin
            acc <= 0;
        end else if (en_acc) begin
            outData <= acc;
            acc     <= sat12(acc + int'(mOut) * int'(vOut));
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en_m) begin
                checkOutput("wr_addr_m", int'(addr_m), mWrites);
                mWrites++;
            end
            if (wr_en_v) begin
                checkOutput("wr_addr_v", int'(addr_v), vWrites);
                vWrites++;
            end
            checkOutput("clear_en_exclusive", int'(clear_acc && en_acc), 0);
            if (output_valid && output_ready) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL unexpected_result: got %0d, expected no result", outData);
                end else begin
                    checkOutput("result", outData, expQ.pop_front());
                end
            end
        end
    end

    task automatic applyStimulus(input int words[$], input bit bubble, input bit holdValid);
        @(posedge clk);
        #1;
        for (int i = 0; i < words.size(); i++) begin
            input_valid = 1'b1;
            in_data     = 12'(words[i]);
            @(posedge clk);
            #1;
            if (bubble && i < words.size() - 1) begin
                input_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        input_valid = holdValid;
    endtask

    task automatic runRows(input int nRows, input int stallRow);
        for (int r = 0; r < nRows; r++) begin
            int lat = 0;
            int en = 0;
            int clr = 0;
            if (r == stallRow) output_ready = 1'b0;
            forever begin
                @(negedge clk);
                if (output_valid || lat > 40) break;
                lat++;
                en  += int'(en_acc);
                clr += int'(clear_acc);
            end
            checkOutput("row_latency", lat, N + 2);
            checkOutput("en_acc_cycles", en, N + 1);
            checkOutput("clear_acc_cycles", clr, 1);
            if (r == 0) input_valid = 1'b0;
            if (r == stallRow) begin
                logic [AM-1:0] am;
                logic [AV-1:0] av;
                int bad = 0;
                am = addr_m;
                av = addr_v;
                repeat (10) begin
                    @(negedge clk);
                    if (!output_valid || en_acc || clear_acc || addr_m != am || addr_v != av) bad++;
                end
                checkOutput("stall_hold_violations", bad, 0);
                @(posedge clk);
                #1;
                output_ready = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (nRows == M) begin
            @(negedge clk);
            checkOutput("back_to_load", int'(input_ready), 1);
        end
    endtask

    task automatic runJob(input int mat[$], input int vec[$], input int exp[$],
                          input bit bubble, input bit holdValid, input int stallRow);
        int words[$];
        words = mat;
        foreach (vec[i]) words.push_back(vec[i]);
        mWrites = 0;
        vWrites = 0;
        foreach (exp[i]) expQ.push_back(exp[i]);
        applyStimulus(words, bubble, holdValid);
        runRows(M, stallRow);
        checkOutput("m_write_count", mWrites, mat.size());
        checkOutput("v_write_count", vWrites, N);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seqM[$];
        int satM[$];
        int diagM[$];
        int noM[$];
        int words[$];
        int cnt;
        seqM  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        satM  = '{2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047};
        diagM = '{2, 0, 0, 0, 2, 0, 0, 0, 2};

        reset        = 1'b1;
        input_valid  = 1'b0;
        output_ready = 1'b1;
        in_data      = '0;
        #12;
        checkOutput("reset_outputs",
                    int'({clear_acc, en_acc, output_valid, wr_en_m, wr_en_v, addr_m, addr_v, input_ready}), 1);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] basic job, v = {1,1,1}");
        runJob(seqM, '{1, 1, 1}, '{6, 15, 24}, 1'b0, 1'b0, -1);

`ifdef MATRIX_REUSE_EN
        $display("[TB] matrix reuse job, v = {2,0,1}");
        runJob(noM, '{2, 0, 1}, '{5, 14, 23}, 1'b0, 1'b0, -1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif

        $display("[TB] saturation job");
        runJob(satM, '{2047, 2047, 2047}, '{2047, 2047, 2047}, 1'b0, 1'b0, -1);

        $display("[TB] backpressure job, stall on row 1");
        runJob(seqM, '{1, 2, 3}, '{14, 32, 50}, 1'b0, 1'b0, 1);

        $display("[TB] bubbled input job, input_valid left high during compute");
        runJob(diagM, '{3, 4, 5}, '{6, 8, 10}, 1'b1, 1'b1, -1);

        $display("[TB] reset during row 2 accumulation");
        mWrites = 0;
        vWrites = 0;
        expQ.push_back(6);
        expQ.push_back(15);
        words = seqM;
        words.push_back(1);
        words.push_back(1);
        words.push_back(1);
        applyStimulus(words, 1'b0, 1'b0);
        runRows(2, -1);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!en_acc && cnt < 20);
        checkOutput("reach_row2_acc", int'(en_acc), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abort_outputs",
                    int'({clear_acc, en_acc, output_valid, wr_en_m, wr_en_v, addr_m, addr_v, input_ready}), 1);
        @(negedge clk);
        reset = 1'b0;
        runJob(seqM, '{1, 1, 1}, '{6, 15, 24}, 1'b0, 1'b0, -1);

        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
